// File: rtl/lsi_uart_arbiter_pkg.sv
// Shared LSI command/response definitions for the two-requester UART arbiter.
package lsi_pkg;
  localparam logic [2:0] LSI_RD          = 3'b000;
  localparam logic [2:0] LSI_WR          = 3'b001;
  localparam logic [1:0] SBSP_CFG        = 2'b00;
  localparam logic [1:0] SBSP_TX         = 2'b01;
  localparam logic [1:0] SBSP_RX         = 2'b10;
  localparam logic [1:0] LSI_ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {CFG_ISSUE, CFG_WAIT, IDLE, ISSUE, WAIT} lsi_state_e;

  typedef struct packed {
    logic [1:0]  sbsp;
    logic [31:0] data;
    logic [2:0]  opc;
    logic [1:0]  bmsk;
  } lsi_cmd_t;
endpackage

// File: rtl/lsi_uart_arbiter_if.sv
// Requester and UART-side LSI signals; slave is the arbiter's view, master the environment's.
interface lsi_uart_arbiter_if;
  logic        r0_vld, r1_vld;
  logic [1:0]  r0_sbsp, r1_sbsp;
  logic [31:0] r0_data, r1_data;
  logic [2:0]  r0_opc, r1_opc;
  logic [1:0]  r0_bmsk, r1_bmsk;
  logic        r0_busy, r1_busy;
  logic        r0_rvld, r1_rvld;
  logic [31:0] r0_rdata, r1_rdata;
  logic [1:0]  r0_rerr, r1_rerr;
  logic        m_vld;
  logic [1:0]  m_sbsp;
  logic [31:0] m_data;
  logic [2:0]  m_opc;
  logic [1:0]  m_bmsk;
  logic        m_busy;
  logic        m_rvld;
  logic [31:0] m_rdata;
  logic [1:0]  m_rerr;
  logic        m_rbusy;
  logic        cfg_done;

  modport slave (
    input  r0_vld, r0_sbsp, r0_data, r0_opc, r0_bmsk,
    input  r1_vld, r1_sbsp, r1_data, r1_opc, r1_bmsk,
    output r0_busy, r0_rvld, r0_rdata, r0_rerr,
    output r1_busy, r1_rvld, r1_rdata, r1_rerr,
    output m_vld, m_sbsp, m_data, m_opc, m_bmsk, m_rbusy, cfg_done,
    input  m_busy, m_rvld, m_rdata, m_rerr
  );

  modport master (
    output r0_vld, r0_sbsp, r0_data, r0_opc, r0_bmsk,
    output r1_vld, r1_sbsp, r1_data, r1_opc, r1_bmsk,
    input  r0_busy, r0_rvld, r0_rdata, r0_rerr,
    input  r1_busy, r1_rvld, r1_rdata, r1_rerr,
    input  m_vld, m_sbsp, m_data, m_opc, m_bmsk, m_rbusy, cfg_done,
    output m_busy, m_rvld, m_rdata, m_rerr
  );
endinterface

// File: rtl/lsi_uart_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer flips only when both requesters competed.
module lsi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic rr_q, rr_d;

  always_comb begin
    gnt  = req;
    rr_d = rr_q;
    if (req == 2'b11) begin
      gnt = rr_q ? 2'b10 : 2'b01;
      if (accept) rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
endmodule

// File: rtl/lsi_uart_arbiter.sv
// Shares the polaris_uart LSI port between two requesters; configures the UART after reset.
module lsi_uart_arbiter
  import lsi_pkg::*;
#(
  parameter logic [31:0] CFG_DATA = 32'h00006C87,
  parameter int          TIMEOUT  = 1024
) (
  input  logic               clk100mhz,
  input  logic               reset,
  lsi_uart_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  lsi_state_e             state_q, state_d;
  logic                   m_vld_q, m_vld_d;
  lsi_cmd_t               m_cmd_q, m_cmd_d;
  logic                   owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cfg_done_q, cfg_done_d;
  logic [1:0]             rvld_q, rvld_d;
  logic [1:0][31:0]       rdata_q, rdata_d;
  logic [1:0][1:0]        rerr_q, rerr_d;
  logic [1:0]             req, gnt;
  lsi_cmd_t               cmd0, cmd1, cfg_cmd;
  logic                   xfer, timeout;

  assign req     = {bus.r1_vld, bus.r0_vld};
  assign cmd0    = '{sbsp: bus.r0_sbsp, data: bus.r0_data, opc: bus.r0_opc, bmsk: bus.r0_bmsk};
  assign cmd1    = '{sbsp: bus.r1_sbsp, data: bus.r1_data, opc: bus.r1_opc, bmsk: bus.r1_bmsk};
  assign cfg_cmd = '{sbsp: SBSP_CFG, data: CFG_DATA, opc: LSI_WR, bmsk: 2'b00};
  assign xfer    = m_vld_q && !bus.m_busy;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  lsi_rr_arb2 u_arb (
    .clk    (clk100mhz),
    .rst    (reset),
    .req    (req),
    .accept (state_q == IDLE),
    .gnt    (gnt)
  );

  always_comb begin
    state_d    = state_q;
    m_vld_d    = m_vld_q;
    m_cmd_d    = m_cmd_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q + 1'b1;
    cfg_done_d = cfg_done_q;
    rvld_d     = '0;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    case (state_q)
      CFG_ISSUE: begin
        m_cmd_d = cfg_cmd;
        m_vld_d = 1'b1;
        if (xfer) begin
          m_vld_d = 1'b0;
          state_d = CFG_WAIT;
          cnt_d   = '0;
        end
      end
      CFG_WAIT: begin
        if (bus.m_rvld && bus.m_rerr == 2'b00) begin
          cfg_done_d = 1'b1;
          state_d    = IDLE;
        end else if (bus.m_rvld || timeout) begin
          m_vld_d = 1'b1;
          state_d = CFG_ISSUE;
        end
      end
      IDLE: begin
        if (|gnt) begin
          m_cmd_d = gnt[1] ? cmd1 : cmd0;
          owner_d = gnt[1];
          m_vld_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          m_vld_d = 1'b0;
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A real response takes priority over a coincident timeout.
        if (bus.m_rvld) begin
          rvld_d[owner_q]  = 1'b1;
          rdata_d[owner_q] = bus.m_rdata;
          rerr_d[owner_q]  = bus.m_rerr;
          state_d          = IDLE;
        end else if (timeout) begin
          rvld_d[owner_q]  = 1'b1;
          rdata_d[owner_q] = '0;
          rerr_d[owner_q]  = LSI_ERR_TIMEOUT;
          state_d          = IDLE;
        end
      end
      default: state_d = CFG_ISSUE;
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      state_q    <= CFG_ISSUE;
      m_vld_q    <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      rvld_q     <= '0;
      rdata_q    <= '0;
      rerr_q     <= '0;
    end else begin
      state_q    <= state_d;
      m_vld_q    <= m_vld_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done_d;
      rvld_q     <= rvld_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
    end
  end

  // Command payload is qualified by m_vld, so it needs no reset.
  always_ff @(posedge clk100mhz) begin
    m_cmd_q <= m_cmd_d;
  end

  assign bus.r0_busy  = reset || !(state_q == IDLE && gnt[0]);
  assign bus.r1_busy  = reset || !(state_q == IDLE && gnt[1]);
  assign bus.r0_rvld  = rvld_q[0];
  assign bus.r1_rvld  = rvld_q[1];
  assign bus.r0_rdata = rdata_q[0];
  assign bus.r1_rdata = rdata_q[1];
  assign bus.r0_rerr  = rerr_q[0];
  assign bus.r1_rerr  = rerr_q[1];
  assign bus.m_vld    = m_vld_q;
  assign bus.m_sbsp   = m_cmd_q.sbsp;
  assign bus.m_data   = m_cmd_q.data;
  assign bus.m_opc    = m_cmd_q.opc;
  assign bus.m_bmsk   = m_cmd_q.bmsk;
  assign bus.m_rbusy  = 1'b0;
  assign bus.cfg_done = cfg_done_q;
endmodule

// File: tb/tb_lsi_uart_arbiter.sv
// Directed bench for lsi_uart_arbiter: config, retry, round-robin, backpressure, timeout, reset.
module tb_lsi_uart_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   xfer_cnt = 0;
  int   base, n, vcnt;

  lsi_uart_arbiter_if bus ();

  lsi_uart_arbiter #(.CFG_DATA(32'h00006C87), .TIMEOUT(16)) dut (
    .clk100mhz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && bus.m_vld && !bus.m_busy) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.r0_vld = 0; bus.r0_sbsp = 0; bus.r0_data = 0; bus.r0_opc = 0; bus.r0_bmsk = 0;
    bus.r1_vld = 0; bus.r1_sbsp = 0; bus.r1_data = 0; bus.r1_opc = 0; bus.r1_bmsk = 0;
    bus.m_busy = 0; bus.m_rvld = 0; bus.m_rdata = 0; bus.m_rerr = 0;
    step(); step(); step();
    chk("rst_m_vld", bus.m_vld, 0);
    chk("rst_r0_busy", bus.r0_busy, 1);
    chk("rst_r1_busy", bus.r1_busy, 1);
    chk("rst_cfg_done", bus.cfg_done, 0);
    chk("rst_r0_rvld", bus.r0_rvld, 0);
    chk("rst_r1_rvld", bus.r1_rvld, 0);
    chk("rst_r0_rdata", bus.r0_rdata, 0);
    chk("rst_r1_rerr", bus.r1_rerr, 0);
    chk("rst_m_rbusy", bus.m_rbusy, 0);

    // configuration write, answered 3 cycles later
    reset = 1'b0;
    step();
    base = xfer_cnt;
    chk("cfg_m_vld", bus.m_vld, 1);
    chk("cfg_m_opc", bus.m_opc, 3'b001);
    chk("cfg_m_sbsp", bus.m_sbsp, 2'b00);
    chk("cfg_m_data", bus.m_data, 32'h00006C87);
    chk("cfg_m_bmsk", bus.m_bmsk, 2'b00);
    chk("cfg_r0_busy", bus.r0_busy, 1);
    step();
    chk("cfg_m_vld_drop", bus.m_vld, 0);
    bus.r0_vld = 1;
    step();
    chk("cfgwait_r0_busy", bus.r0_busy, 1);
    bus.r0_vld = 0;
    step();
    bus.m_rvld = 1; bus.m_rerr = 2'b00;
    step();
    bus.m_rvld = 0;
    chk("cfg_done_set", bus.cfg_done, 1);
    chk("cfg_no_r0_rvld", bus.r0_rvld, 0);
    chk("cfg_xfers", xfer_cnt - base, 1);

    // configuration retry after an error response
    reset = 1'b1;
    step(); step();
    chk("rst2_cfg_done", bus.cfg_done, 0);
    reset = 1'b0;
    base = xfer_cnt;
    step();
    chk("retry_m_vld1", bus.m_vld, 1);
    step();
    bus.m_rvld = 1; bus.m_rerr = 2'b01;
    step();
    bus.m_rvld = 0; bus.m_rerr = 2'b00;
    chk("retry_m_vld2", bus.m_vld, 1);
    chk("retry_cfg_done0", bus.cfg_done, 0);
    step();
    chk("retry_m_vld_drop", bus.m_vld, 0);
    bus.m_rvld = 1;
    step();
    bus.m_rvld = 0;
    chk("retry_cfg_done1", bus.cfg_done, 1);
    chk("retry_xfers", xfer_cnt - base, 2);

    // both requesters read at once: r0 first, then r1
    bus.r0_opc = 3'b000; bus.r0_sbsp = 2'b10; bus.r0_data = 32'hA0;
    bus.r1_opc = 3'b000; bus.r1_sbsp = 2'b10; bus.r1_data = 32'hB1;
    bus.r0_vld = 1; bus.r1_vld = 1;
    #1;
    chk("rr1_r0_busy", bus.r0_busy, 0);
    chk("rr1_r1_busy", bus.r1_busy, 1);
    step();
    bus.r0_vld = 0;
    chk("rr1_m_vld", bus.m_vld, 1);
    chk("rr1_m_data", bus.m_data, 32'hA0);
    chk("rr1_m_sbsp", bus.m_sbsp, 2'b10);
    chk("rr1_m_opc", bus.m_opc, 3'b000);
    chk("rr1_issue_r1_busy", bus.r1_busy, 1);
    step();
    bus.m_rvld = 1; bus.m_rdata = 32'h41;
    step();
    bus.m_rvld = 0;
    chk("rr1_r0_rvld", bus.r0_rvld, 1);
    chk("rr1_r0_rdata", bus.r0_rdata, 32'h41);
    chk("rr1_r0_rerr", bus.r0_rerr, 0);
    chk("rr1_r1_rvld", bus.r1_rvld, 0);
    #1;
    chk("rr1_r1_grant", bus.r1_busy, 0);
    step();
    bus.r1_vld = 0;
    chk("rr1_r0_pulse_end", bus.r0_rvld, 0);
    chk("rr1_m_data_r1", bus.m_data, 32'hB1);
    step();
    bus.m_rvld = 1; bus.m_rdata = 32'h42;
    step();
    bus.m_rvld = 0;
    chk("rr1_r1_rvld", bus.r1_rvld, 1);
    chk("rr1_r1_rdata", bus.r1_rdata, 32'h42);
    chk("rr1_r0_rdata_hold", bus.r0_rdata, 32'h41);

    // second contention: pointer now favours r1
    bus.r0_data = 32'hA2; bus.r1_data = 32'hB2;
    bus.r0_vld = 1; bus.r1_vld = 1;
    #1;
    chk("rr2_r1_busy", bus.r1_busy, 0);
    chk("rr2_r0_busy", bus.r0_busy, 1);
    step();
    bus.r1_vld = 0;
    chk("rr2_m_data", bus.m_data, 32'hB2);
    step();
    bus.m_rvld = 1; bus.m_rdata = 32'h43;
    step();
    bus.m_rvld = 0;
    chk("rr2_r1_rdata", bus.r1_rdata, 32'h43);
    chk("rr2_r1_rvld", bus.r1_rvld, 1);
    #1;
    chk("rr2_r0_busy_after", bus.r0_busy, 0);
    step();
    bus.r0_vld = 0;
    chk("rr2_m_data_r0", bus.m_data, 32'hA2);
    step();
    bus.m_rvld = 1; bus.m_rdata = 32'h44;
    step();
    bus.m_rvld = 0;
    chk("rr2_r0_rvld", bus.r0_rvld, 1);
    chk("rr2_r0_rdata", bus.r0_rdata, 32'h44);

    // r1 write with UART busy for 4 cycles
    bus.r1_opc = 3'b001; bus.r1_sbsp = 2'b01; bus.r1_data = 32'h5A5A; bus.r1_bmsk = 2'b11;
    bus.r1_vld = 1;
    base = xfer_cnt;
    step();
    bus.r1_vld = 0;
    bus.m_busy = 1;
    vcnt = (bus.m_vld && bus.m_data == 32'h5A5A && bus.m_bmsk == 2'b11 && bus.m_opc == 3'b001) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.m_vld && bus.m_data == 32'h5A5A && bus.m_bmsk == 2'b11 && bus.m_opc == 3'b001) vcnt++;
    end
    bus.m_busy = 0;
    step();
    chk("bp_m_vld_drop", bus.m_vld, 0);
    chk("bp_vld_cycles", vcnt, 5);
    chk("bp_xfers", xfer_cnt - base, 1);
    bus.m_rvld = 1; bus.m_rdata = 32'h77;
    step();
    bus.m_rvld = 0;
    chk("bp_r1_rvld", bus.r1_rvld, 1);
    chk("bp_r1_rdata", bus.r1_rdata, 32'h77);
    chk("bp_r0_rvld", bus.r0_rvld, 0);
    step();
    chk("bp_r1_pulse_end", bus.r1_rvld, 0);

    // timeout on an r0 read, then a stray late response
    bus.r0_opc = 3'b000; bus.r0_sbsp = 2'b10;
    bus.r0_vld = 1;
    step();
    bus.r0_vld = 0;
    step();
    n = 0;
    while (!bus.r0_rvld && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_r0_rerr", bus.r0_rerr, 2'b11);
    chk("to_r0_rdata", bus.r0_rdata, 0);
    bus.m_rvld = 1; bus.m_rdata = 32'h99;
    step();
    bus.m_rvld = 0;
    chk("stray_r0_rvld", bus.r0_rvld, 0);
    chk("stray_r1_rvld", bus.r1_rvld, 0);
    chk("stray_r0_rdata", bus.r0_rdata, 0);

    // reset while r1 waits for its response
    bus.r1_opc = 3'b000;
    bus.r1_vld = 1;
    step();
    bus.r1_vld = 0;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("rstw_cfg_done", bus.cfg_done, 0);
    chk("rstw_m_vld", bus.m_vld, 0);
    chk("rstw_r1_busy", bus.r1_busy, 1);
    chk("rstw_r1_rvld", bus.r1_rvld, 0);
    bus.m_rvld = 1; bus.m_rdata = 32'h55;
    step();
    bus.m_rvld = 0;
    reset = 1'b0;
    step();
    chk("rstw_cfg_reissue", bus.m_vld, 1);
    chk("rstw_cfg_data", bus.m_data, 32'h00006C87);
    chk("rstw_r1_no_resp", bus.r1_rvld, 0);
    chk("rstw_r1_rdata", bus.r1_rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
